fir_axilite_ctrl: RTL
=====================

# fir_axilite_ctrl

Control and configuration front end for the FIR engine. It terminates the AXI-Lite slave port and holds the ap_ctrl and data_length registers. It owns the tap coefficient BRAM port and hands that port to the FIR engine while a run is active. It issues the single-cycle start to the engine and tracks done/idle from the engine's completion pulse.

## Interface
- pADDR_WIDTH, 12, AXI-Lite and BRAM address width (byte addresses)
- pDATA_WIDTH, 32, data width
- Tape_Num, 11, number of taps; tap window is 0x20 .. 0x20+4*(Tape_Num-1)

Ports:
- axis_clk  in  1  single clock
- axis_rst_n  in  1  asynchronous, active-low reset
- awvalid / awready  in / out  1  write address handshake
- awaddr  in  pADDR_WIDTH  write byte address
- wvalid / wready  in / out  1  write data handshake
- wdata  in  pDATA_WIDTH  write data
- arvalid / arready  in / out  1  read address handshake
- araddr  in  pADDR_WIDTH  read byte address
- rvalid / rready  out / in  1  read data handshake
- rdata  out  pDATA_WIDTH  read data
- tap_WE  out  4  tap BRAM byte write enables
- tap_EN  out  1  tap BRAM enable
- tap_Di  out  pDATA_WIDTH  tap BRAM write data
- tap_A  out  pADDR_WIDTH  tap BRAM byte address
- tap_Do  in  pDATA_WIDTH  tap BRAM read data, valid one cycle after the enabled edge
- eng_tap_EN  in  1  engine tap read enable, honoured only in RUN
- eng_tap_A  in  pADDR_WIDTH  engine tap address, honoured only in RUN
- eng_start  out  1  one-cycle start pulse to the engine
- eng_done  in  1  one-cycle pulse when the last output handshake completes
- data_length  out  32  data_length register value

## Operation
- **ap FSM states:** IDLE, RUN, DONE. Reset state is IDLE.
- **ap_ctrl register (0x00):** bit0 ap_start, bit1 ap_done, bit2 ap_idle. Reads return {29'b0, idle, done, 1'b0}.
  - IDLE: idle=1, done=0.
  - RUN: idle=0, done=0.
  - DONE: idle=1, done=1.
- **Start:** a write to 0x00 with wdata[0]=1 in IDLE or DONE pulses eng_start for one cycle and moves the FSM to RUN. The same write in RUN is ignored, but its handshake still completes.
- **Done:** eng_done in RUN moves the FSM to DONE. eng_done outside RUN is ignored.
- **Done clear:** a completed read of 0x00 (rvalid&&rready) while in DONE moves the FSM to IDLE (read-to-clear). rdata for that read still shows done=1.
- **data_length register (0x10):** reset value 0. Writes are ignored in RUN. Always readable.
- **Tap window, outside RUN:**
  - Write: tap_EN=1, tap_WE=4'hF, tap_A=awaddr-0x20, tap_Di=wdata.
  - Read: tap_EN=1, tap_WE=0, tap_A=araddr-0x20; rdata=tap_Do.
- **Tap window, in RUN:** the BRAM port is driven as tap_EN=eng_tap_EN, tap_A=eng_tap_A, tap_WE=0. Config tap writes are dropped after handshake. Config tap reads return 0.
- **Unmapped addresses:** writes complete and are discarded; reads return 0.
- **Bus FSM states:** B_IDLE, B_WR, B_RA, B_RW, B_RD. One transaction is served at a time. If awvalid&&wvalid and arvalid are sampled on the same edge, the write is served first.
- Because transactions are serialized, no config BRAM access is in flight when the FSM switches to RUN.

## Timing
- **Write:**
  - Edge E0 samples awvalid&&wvalid in B_IDLE; the bus FSM enters B_WR.
  - awready=wready=1 for the single cycle after E0, together with the tap port drive.
  - The BRAM and registers update at E1; the FSM returns to B_IDLE.
  - eng_start is high in the cycle after E1.
- **Read:**
  - E0 samples arvalid; the FSM enters B_RA, with arready=1 and tap_EN for that one cycle.
  - E1: B_RW, tap_Do valid.
  - E2: B_RD, where rdata is registered and rvalid=1.
  - rvalid and rdata are held until rready is sampled, then the FSM returns to B_IDLE.
  - rvalid rises 3 cycles after arvalid is sampled for every address, registers included.
- **Awvalid/wvalid skew:** awvalid without wvalid, or the reverse, is not accepted. The FSM waits for both.
- **Simultaneous events:** eng_done and an ap_start write on the same edge → DONE wins (start ignored, FSM was in RUN).
- **Reset values:** awready=wready=arready=rvalid=0, rdata=0, tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0, eng_start=0, data_length=0, ap FSM in IDLE (0x00 reads 0x4).
- **Reset mid-operation:** axis_rst_n low forces all of the above on the next evaluation, asynchronously. This includes an in-flight read, which drops rvalid, and an active RUN. BRAM contents are not touched.

## Test plan
- **Reset read:** after reset, read 0x00 → rdata=0x4. Read 0x10 → 0.
- **Tap round trip:** write coefficients 0,-10,-9,23,56,63,56,23,-9,-10,0 to 0x20..0x48 → each read-back matches, e.g. 0x2C returns 23. tap_A=0x0C and tap_WE=4'hF are seen on that write.
- **Start/run/done sequence:**
  - Write data_length=600, then 0x00=1 → one-cycle eng_start.
  - A 0x00 read returns 0x0.
  - eng_done pulse → 0x00 reads 0x6, then a second read returns 0x4.
- **Run protection:**
  - During RUN, write 0x24=99 and 0x10=5 → handshakes complete.
  - Config tap reads return 0 and tap_A follows eng_tap_A.
  - After done, 0x24 reads -10 and 0x10 reads 600.
- **Arbitration and backpressure:**
  - Assert a write and arvalid on the same edge → the write completes first, then the read.
  - Hold rready=0 for 5 cycles → rvalid and rdata stay stable.
- **Mid-run reset:** reset in RUN → 0x00 reads 0x4 and eng_start stays 0. Previously written taps still read back correctly.

Source files
------------

// File: rtl/fir_axilite_ctrl.sv
// fir_axilite_ctrl: AXI-Lite configuration front end for the FIR engine.
// Holds ap_ctrl / data_length, owns the tap BRAM port outside a run and
// lends it to the engine while the run is active. Bus transactions are
// strictly serialized, with writes taking priority over reads.
module fir_axilite_ctrl #(
    parameter int pADDR_WIDTH = 12,
    parameter int pDATA_WIDTH = 32,
    parameter int Tape_Num    = 11
) (
    input  logic                   axis_clk,
    input  logic                   axis_rst_n,
    // AXI-Lite write
    input  logic                   awvalid,
    output logic                   awready,
    input  logic [pADDR_WIDTH-1:0] awaddr,
    input  logic                   wvalid,
    output logic                   wready,
    input  logic [pDATA_WIDTH-1:0] wdata,
    // AXI-Lite read
    input  logic                   arvalid,
    output logic                   arready,
    input  logic [pADDR_WIDTH-1:0] araddr,
    output logic                   rvalid,
    input  logic                   rready,
    output logic [pDATA_WIDTH-1:0] rdata,
    // tap coefficient BRAM port
    output logic [3:0]             tap_WE,
    output logic                   tap_EN,
    output logic [pDATA_WIDTH-1:0] tap_Di,
    output logic [pADDR_WIDTH-1:0] tap_A,
    input  logic [pDATA_WIDTH-1:0] tap_Do,
    // engine side
    input  logic                   eng_tap_EN,
    input  logic [pADDR_WIDTH-1:0] eng_tap_A,
    output logic                   eng_start,
    input  logic                   eng_done,
    output logic [31:0]            data_length
);

    localparam logic [pADDR_WIDTH-1:0] ADDR_CTRL = '0;
    localparam logic [pADDR_WIDTH-1:0] ADDR_LEN  = pADDR_WIDTH'(16);
    localparam logic [pADDR_WIDTH-1:0] TAP_BASE  = pADDR_WIDTH'(32);
    localparam logic [pADDR_WIDTH-1:0] TAP_LAST  = pADDR_WIDTH'(32 + 4 * (Tape_Num - 1));

    typedef enum logic [1:0] {AP_IDLE, AP_RUN, AP_DONE} ap_state_t;
    typedef enum logic [2:0] {B_IDLE, B_WR, B_RA, B_RW, B_RD} bus_state_t;

    ap_state_t               ap_q, ap_d;
    bus_state_t              bus_q, bus_d;
    logic [pADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [pDATA_WIDTH-1:0]  wdata_q, wdata_d;
    logic [pDATA_WIDTH-1:0]  rdata_q, rdata_d;
    logic                    cfg_rd_q, cfg_rd_d;
    logic                    eng_start_q, eng_start_d;
    logic [31:0]             data_length_q, data_length_d;

    logic                    run;
    logic                    hit_ctrl, hit_len, hit_tap;
    logic [pADDR_WIDTH-1:0]  tap_off;
    logic                    wr_fire, rd_fire, start_req;
    logic [pDATA_WIDTH-1:0]  rd_mux;

    // Address decode on the latched transaction address
    always_comb begin
        run      = (ap_q == AP_RUN);
        hit_ctrl = (addr_q == ADDR_CTRL);
        hit_len  = (addr_q == ADDR_LEN);
        hit_tap  = (addr_q >= TAP_BASE) && (addr_q <= TAP_LAST);
        tap_off  = addr_q - TAP_BASE;
        wr_fire  = (bus_q == B_WR);
        rd_fire  = (bus_q == B_RD) && rready;
        start_req = wr_fire && hit_ctrl && wdata_q[0];
    end

    // Handshake outputs are pure decodes of the bus state
    always_comb begin
        awready = (bus_q == B_WR);
        wready  = (bus_q == B_WR);
        arready = (bus_q == B_RA);
        rvalid  = (bus_q == B_RD);
        rdata   = rdata_q;
        eng_start   = eng_start_q;
        data_length = data_length_q;
    end

    // Read data source, captured when leaving B_RW (BRAM output valid then)
    always_comb begin
        rd_mux = '0;
        if (hit_ctrl) begin
            rd_mux[2] = (ap_q != AP_RUN);
            rd_mux[1] = (ap_q == AP_DONE);
        end else if (hit_len) begin
            rd_mux = pDATA_WIDTH'(data_length_q);
        end else if (hit_tap && cfg_rd_q) begin
            rd_mux = tap_Do;
        end
    end

    // Bus FSM: one transaction at a time, write wins a same-edge tie
    always_comb begin
        bus_d    = bus_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cfg_rd_d = cfg_rd_q;
        case (bus_q)
            B_IDLE: begin
                if (awvalid && wvalid) begin
                    bus_d   = B_WR;
                    addr_d  = awaddr;
                    wdata_d = wdata;
                end else if (arvalid) begin
                    bus_d  = B_RA;
                    addr_d = araddr;
                end
            end
            B_WR: bus_d = B_IDLE;
            B_RA: begin
                bus_d = B_RW;
                // remember whether the BRAM read was ours or the engine's
                cfg_rd_d = !run;
            end
            B_RW: begin
                bus_d   = B_RD;
                rdata_d = rd_mux;
            end
            B_RD: if (rready) bus_d = B_IDLE;
            default: bus_d = B_IDLE;
        endcase
    end

    // Tap BRAM port mux: engine owns it in RUN, config bus otherwise
    always_comb begin
        tap_EN = 1'b0;
        tap_WE = 4'h0;
        tap_A  = '0;
        tap_Di = '0;
        if (run) begin
            tap_EN = eng_tap_EN;
            tap_A  = eng_tap_A;
        end else if (wr_fire && hit_tap) begin
            tap_EN = 1'b1;
            tap_WE = 4'hF;
            tap_A  = tap_off;
            tap_Di = wdata_q;
        end else if ((bus_q == B_RA) && hit_tap) begin
            tap_EN = 1'b1;
            tap_A  = tap_off;
        end
    end

    // ap FSM and data_length register
    always_comb begin
        ap_d          = ap_q;
        eng_start_d   = 1'b0;
        data_length_d = data_length_q;
        case (ap_q)
            AP_IDLE: begin
                if (start_req) begin
                    ap_d        = AP_RUN;
                    eng_start_d = 1'b1;
                end
            end
            AP_RUN: begin
                if (eng_done) ap_d = AP_DONE;
            end
            AP_DONE: begin
                if (start_req) begin
                    ap_d        = AP_RUN;
                    eng_start_d = 1'b1;
                end else if (rd_fire && hit_ctrl && rdata_q[1]) begin
                    // clear only if the reader actually saw done=1
                    ap_d = AP_IDLE;
                end
            end
            default: ap_d = AP_IDLE;
        endcase
        if (wr_fire && hit_len && !run) data_length_d = wdata_q[31:0];
    end

    // State registers
    always_ff @(posedge axis_clk or negedge axis_rst_n) begin
        if (!axis_rst_n) begin
            ap_q          <= AP_IDLE;
            bus_q         <= B_IDLE;
            addr_q        <= '0;
            wdata_q       <= '0;
            rdata_q       <= '0;
            cfg_rd_q      <= 1'b0;
            eng_start_q   <= 1'b0;
            data_length_q <= '0;
        end else begin
            ap_q          <= ap_d;
            bus_q         <= bus_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rdata_q       <= rdata_d;
            cfg_rd_q      <= cfg_rd_d;
            eng_start_q   <= eng_start_d;
            data_length_q <= data_length_d;
        end
    end

endmodule
